// File: rtl/msg_pkg.sv
// Shared message-framing definitions for the OPB message parser (receive side)
// and msg_write (transmit side).
package msg_pkg;

  localparam logic [7:0] HDR_WRREQ  = 8'h5A;
  localparam logic [7:0] HDR_RDRESP = 8'h5B;
  localparam logic [7:0] HDR_ERROR  = 8'h5E;

  localparam logic [7:0] TAIL_WRREQ  = ~HDR_WRREQ;
  localparam logic [7:0] TAIL_RDRESP = ~HDR_RDRESP;
  localparam logic [7:0] TAIL_ERROR  = ~HDR_ERROR;

  localparam int FRAME_BYTES = 10;
  localparam int FRAME_W     = FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } msg_state_t;

  // Header, 8-byte payload MSB first, then the complemented header as tail.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0]  hdr,
                                                     input logic [63:0] payload);
    return {hdr, payload, ~hdr};
  endfunction

endpackage

// File: rtl/msg_pend_slot.sv
// One-entry request holding register: captures when empty (or being freed this
// cycle) and flags a drop when a request finds the entry still occupied.
module msg_pend_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_capture,
  input  logic [W-1:0] i_data,
  input  logic         i_free,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_drop
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // A capture on the freeing cycle wins, so back-to-back requests are never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_capture && (!r_valid || i_free)) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_free) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_drop  = i_capture & r_valid & ~i_free;

endmodule

// File: rtl/msg_write.sv
// Builds 10-byte read-response / error-report frames and streams them byte by
// byte into the UART TX FIFO, aborting a frame if the FIFO stays full too long.
module msg_write
  import msg_pkg::*;
#(
  parameter logic [15:0] STALL_LIMIT = 16'd50000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic        OPB_RD_DONE,
  input  logic [31:0] OPB_DI,
  input  logic [31:0] OPB_RD_ADDR,
  input  logic        ERR_REQ,
  input  logic [7:0]  ERR_CODE,
  output logic        TX_FIFO_WR,
  output logic [7:0]  TX_FIFO_DATA,
  input  logic        TX_FIFO_FULL,
  output logic        BUSY,
  output logic [7:0]  DROP_CNT,
  output logic        STALL_ERR
);

  localparam logic [15:0] STALL_LAST = STALL_LIMIT - 16'd1;
  localparam logic [3:0]  LAST_BYTE  = 4'(FRAME_BYTES - 1);

  msg_state_t         r_state;
  msg_state_t         w_state_next;
  logic               r_sel_rd;
  logic [FRAME_W-1:0] r_frame;
  logic [3:0]         r_byte_cnt;
  logic [15:0]        r_stall_cnt;
  logic [7:0]         r_drop_cnt;

  logic               w_rd_pend;
  logic [63:0]        w_rd_data;
  logic               w_rd_drop;
  logic               w_rd_free;
  logic               w_err_pend;
  logic [7:0]         w_err_code;
  logic               w_err_drop;
  logic               w_err_free;
  logic               w_rd_any;
  logic               w_err_any;
  logic               w_wr;
  logic               w_stall_abort;
  logic [8:0]         w_drop_sum;

  assign w_rd_free  = (r_state == ST_LOAD) &  r_sel_rd;
  assign w_err_free = (r_state == ST_LOAD) & ~r_sel_rd;

  msg_pend_slot #(.W(64)) u_rd_slot (
    .clk       (OPB_CLK),
    .rst_n     (OPB_RST_N),
    .i_capture (OPB_RD_DONE),
    .i_data    ({OPB_RD_ADDR, OPB_DI}),
    .i_free    (w_rd_free),
    .o_valid   (w_rd_pend),
    .o_data    (w_rd_data),
    .o_drop    (w_rd_drop)
  );

  msg_pend_slot #(.W(8)) u_err_slot (
    .clk       (OPB_CLK),
    .rst_n     (OPB_RST_N),
    .i_capture (ERR_REQ),
    .i_data    (ERR_CODE),
    .i_free    (w_err_free),
    .o_valid   (w_err_pend),
    .o_data    (w_err_code),
    .o_drop    (w_err_drop)
  );

  // Incoming pulses are seen directly in IDLE so LOAD follows the request by one cycle.
  assign w_rd_any  = w_rd_pend  | OPB_RD_DONE;
  assign w_err_any = w_err_pend | ERR_REQ;

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_wr          = 1'b0;
    w_stall_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_any || w_err_any) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_wr          = ~TX_FIFO_FULL;
        w_stall_abort = TX_FIFO_FULL & (r_stall_cnt == STALL_LAST);
        if (w_wr && (r_byte_cnt == LAST_BYTE)) begin
          w_state_next = ST_DONE;
        end else if (w_stall_abort) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_sel_rd    <= 1'b0;
      r_frame     <= '0;
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sel_rd <= w_rd_any;
        end
        ST_LOAD: begin
          r_frame     <= r_sel_rd ? build_frame(HDR_RDRESP, w_rd_data)
                                  : build_frame(HDR_ERROR, {24'h0, w_err_code, 32'h0});
          r_byte_cnt  <= '0;
          r_stall_cnt <= '0;
        end
        ST_SEND: begin
          if (w_wr) begin
            r_frame     <= {r_frame[FRAME_W-9:0], 8'h00};
            r_byte_cnt  <= r_byte_cnt + 4'd1;
            r_stall_cnt <= '0;
          end else if (!w_stall_abort) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {8'h00, w_rd_drop} + {8'h00, w_err_drop};

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign TX_FIFO_WR   = w_wr;
  assign TX_FIFO_DATA = r_frame[FRAME_W-1 -: 8];
  assign BUSY         = (r_state != ST_IDLE) | w_rd_pend | w_err_pend;
  assign DROP_CNT     = r_drop_cnt;
  assign STALL_ERR    = w_stall_abort;

endmodule

// File: tb/tb_msg_write.sv
// Self-checking bench for msg_write: literal frame table, hand-written
// back-pressure / stall / overflow / reset sequences, and randomized traffic.
module tb_msg_write;

  localparam logic [15:0] LIMIT = 16'd32;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST_N = 1'b0;
  logic        OPB_RD_DONE = 1'b0;
  logic [31:0] OPB_DI = '0;
  logic [31:0] OPB_RD_ADDR = '0;
  logic        ERR_REQ = 1'b0;
  logic [7:0]  ERR_CODE = '0;
  logic        TX_FIFO_WR;
  logic [7:0]  TX_FIFO_DATA;
  logic        TX_FIFO_FULL = 1'b0;
  logic        BUSY;
  logic [7:0]  DROP_CNT;
  logic        STALL_ERR;

  msg_write #(.STALL_LIMIT(LIMIT)) dut (
    .OPB_CLK      (OPB_CLK),
    .OPB_RST_N    (OPB_RST_N),
    .OPB_RD_DONE  (OPB_RD_DONE),
    .OPB_DI       (OPB_DI),
    .OPB_RD_ADDR  (OPB_RD_ADDR),
    .ERR_REQ      (ERR_REQ),
    .ERR_CODE     (ERR_CODE),
    .TX_FIFO_WR   (TX_FIFO_WR),
    .TX_FIFO_DATA (TX_FIFO_DATA),
    .TX_FIFO_FULL (TX_FIFO_FULL),
    .BUSY         (BUSY),
    .DROP_CNT     (DROP_CNT),
    .STALL_ERR    (STALL_ERR)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  int cyc = 0;
  always @(posedge OPB_CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int stall_seen = 0;
  int req_cyc = 0;
  int idle_cyc = 0;
  int full_run = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  code;
    logic [79:0] exp_frame;
  } vec_t;
  vec_t vt[4];

  // Byte monitor, sampled on the falling edge.
  always @(negedge OPB_CLK) begin
    if (TX_FIFO_WR === 1'b1) begin
      got_q.push_back(TX_FIFO_DATA);
      got_cyc.push_back(cyc);
      n_checks++;
      if (TX_FIFO_FULL !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_while_full: TX_FIFO_WR=1 with TX_FIFO_FULL=%b at cycle %0d", TX_FIFO_FULL, cyc);
      end
    end
    if (STALL_ERR === 1'b1) stall_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge OPB_CLK);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // Reference: frame = header, 8 payload bytes MSB first, tail = 255 - header.
  task automatic model_frame(input bit is_err, input logic [31:0] addr,
                             input logic [31:0] data, input logic [7:0] code);
    logic [7:0]  hdr;
    logic [63:0] payload;
    hdr     = is_err ? 8'h5E : 8'h5B;
    payload = is_err ? (64'(code) << 32) : {addr, data};
    exp_q.push_back(hdr);
    for (int i = 7; i >= 0; i--) exp_q.push_back(8'((payload >> (8 * i)) & 64'hFF));
    exp_q.push_back(8'hFF - hdr);
  endtask

  task automatic req(input bit rd, input bit er, input logic [31:0] a,
                     input logic [31:0] d, input logic [7:0] c);
    OPB_RD_ADDR = a;
    OPB_DI      = d;
    ERR_CODE    = c;
    OPB_RD_DONE = rd;
    ERR_REQ     = er;
    req_cyc     = cyc;
    tick();
    OPB_RD_DONE = 1'b0;
    ERR_REQ     = 1'b0;
  endtask

  task automatic wait_idle(input int max, input bit rnd_full);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < max) begin
      if (rnd_full) begin
        TX_FIFO_FULL = (full_run < 8) && ($urandom_range(0, 3) == 0);
        full_run     = TX_FIFO_FULL ? full_run + 1 : 0;
      end
      tick();
      n++;
    end
    TX_FIFO_FULL = 1'b0;
    full_run     = 0;
    idle_cyc     = cyc;
    chk("idle_reached", 64'(n < max), 64'd1);
  endtask

  task automatic wait_bytes(input int nb, input int max);
    int n;
    n = 0;
    while (got_q.size() < nb && n < max) begin
      tick();
      n++;
    end
    chk("bytes_reached", 64'(got_q.size()), 64'(nb));
  endtask

  task automatic cmp_frames(input string name);
    chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    clear_q();
  endtask

  initial begin
    int s0;
    int sz;
    bit        r_is_err;
    bit        r_both;
    logic [31:0] ra, rd;
    logic [7:0]  rc;
    logic [79:0] f;

    vt[0] = '{1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 8'h00, 80'h5B_0000_1004_DEAD_BEEF_A4};
    vt[1] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 8'h02, 80'h5E_0000_0002_0000_0000_A1};
    vt[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00, 80'h5B_FFFF_FFFF_0000_0000_A4};
    vt[3] = '{1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 8'hFF, 80'h5E_0000_00FF_0000_0000_A1};

    // Reset state
    repeat (3) tick();
    chk("rst_wr", 64'(TX_FIFO_WR), 64'd0);
    chk("rst_data", 64'(TX_FIFO_DATA), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_drop", 64'(DROP_CNT), 64'd0);
    chk("rst_stall", 64'(STALL_ERR), 64'd0);
    OPB_RST_N = 1'b1;
    repeat (2) tick();
    clear_q();

    // Table-driven single frames with literal expectations
    for (int v = 0; v < 4; v++) begin
      req(!vt[v].is_err, vt[v].is_err, vt[v].addr, vt[v].data, vt[v].code);
      wait_idle(100, 1'b0);
      f = vt[v].exp_frame;
      for (int k = 9; k >= 0; k--) exp_q.push_back(f[8 * k +: 8]);
      if (v == 0 && got_cyc.size() >= 10) begin
        chk("lat_first_byte", 64'(got_cyc[0] - req_cyc), 64'd2);
        chk("lat_last_byte", 64'(got_cyc[9] - req_cyc), 64'd11);
        chk("lat_busy_low", 64'(idle_cyc - req_cyc), 64'd13);
      end
      cmp_frames($sformatf("vec%0d", v));
      $display("vector %0d done", v);
    end

    // Back-pressure: FULL for 20 cycles after byte 3
    s0 = stall_seen;
    req(1'b1, 1'b0, 32'hA5A5_0001, 32'h0102_0304, 8'h00);
    model_frame(1'b0, 32'hA5A5_0001, 32'h0102_0304, 8'h00);
    wait_bytes(3, 50);
    TX_FIFO_FULL = 1'b1;
    repeat (20) tick();
    chk("bp_held", 64'(got_q.size()), 64'd3);
    TX_FIFO_FULL = 1'b0;
    wait_idle(100, 1'b0);
    chk("bp_no_stall", 64'(stall_seen - s0), 64'd0);
    cmp_frames("bp");
    $display("back-pressure done");

    // Boundary: LIMIT-1 full cycles must not abort
    s0 = stall_seen;
    req(1'b1, 1'b0, 32'h0BAD_F00D, 32'h7777_8888, 8'h00);
    model_frame(1'b0, 32'h0BAD_F00D, 32'h7777_8888, 8'h00);
    wait_bytes(4, 50);
    TX_FIFO_FULL = 1'b1;
    repeat (int'(LIMIT) - 1) tick();
    TX_FIFO_FULL = 1'b0;
    wait_idle(100, 1'b0);
    chk("edge_no_stall", 64'(stall_seen - s0), 64'd0);
    cmp_frames("edge");
    $display("stall boundary done");

    // Stall abort after byte 2
    s0 = stall_seen;
    req(1'b1, 1'b0, 32'hCAFE_0000, 32'h1111_2222, 8'h00);
    wait_bytes(2, 50);
    TX_FIFO_FULL = 1'b1;
    repeat (int'(LIMIT) + 8) tick();
    chk("abort_stall_pulse", 64'(stall_seen - s0), 64'd1);
    chk("abort_bytes", 64'(got_q.size()), 64'd2);
    chk("abort_idle", 64'(BUSY), 64'd0);
    TX_FIFO_FULL = 1'b0;
    clear_q();
    req(1'b0, 1'b1, 32'h0, 32'h0, 8'h33);
    model_frame(1'b1, 32'h0, 32'h0, 8'h33);
    wait_idle(100, 1'b0);
    cmp_frames("after_abort");
    $display("stall abort done");

    // Simultaneous read + error
    req(1'b1, 1'b1, 32'h0000_2000, 32'hFEED_FACE, 8'h02);
    model_frame(1'b0, 32'h0000_2000, 32'hFEED_FACE, 8'h00);
    model_frame(1'b1, 32'h0, 32'h0, 8'h02);
    wait_idle(200, 1'b0);
    chk("simul_drop", 64'(DROP_CNT), 64'd0);
    cmp_frames("simul");
    $display("simultaneous done");

    // Overflow: three reads two cycles apart
    req(1'b1, 1'b0, 32'h0000_0010, 32'h0000_00A0, 8'h00);
    tick();
    req(1'b1, 1'b0, 32'h0000_0020, 32'h0000_00B0, 8'h00);
    tick();
    req(1'b1, 1'b0, 32'h0000_0030, 32'h0000_00C0, 8'h00);
    model_frame(1'b0, 32'h0000_0010, 32'h0000_00A0, 8'h00);
    model_frame(1'b0, 32'h0000_0020, 32'h0000_00B0, 8'h00);
    wait_idle(200, 1'b0);
    chk("ovf_drop", 64'(DROP_CNT), 64'd1);
    cmp_frames("ovf");
    $display("overflow done");

    // Randomized traffic with random back-pressure
    for (int it = 0; it < 30; it++) begin
      r_is_err = 1'($urandom_range(0, 1));
      r_both   = ($urandom_range(0, 3) == 0);
      ra = $urandom;
      rd = $urandom;
      rc = 8'($urandom);
      req(r_both | !r_is_err, r_both | r_is_err, ra, rd, rc);
      if (r_both | !r_is_err) model_frame(1'b0, ra, rd, rc);
      if (r_both | r_is_err)  model_frame(1'b1, ra, rd, rc);
      wait_idle(600, 1'b1);
      cmp_frames($sformatf("rnd%0d", it));
      $display("random %0d addr=%h data=%h code=%h err=%0d both=%0d", it, ra, rd, rc, r_is_err, r_both);
    end
    chk("rnd_drop", 64'(DROP_CNT), 64'd1);

    // DROP_CNT saturation under continuous requests
    OPB_RD_DONE = 1'b1;
    ERR_REQ     = 1'b1;
    repeat (200) tick();
    OPB_RD_DONE = 1'b0;
    ERR_REQ     = 1'b0;
    wait_idle(300, 1'b0);
    chk("drop_sat", 64'(DROP_CNT), 64'hFF);
    clear_q();
    $display("saturation done");

    // Reset mid-frame at byte 5
    req(1'b1, 1'b0, 32'h5555_AAAA, 32'h0F0F_F0F0, 8'h00);
    wait_bytes(5, 50);
    OPB_RST_N = 1'b0;
    #1;
    chk("mid_rst_wr", 64'(TX_FIFO_WR), 64'd0);
    chk("mid_rst_busy", 64'(BUSY), 64'd0);
    chk("mid_rst_drop", 64'(DROP_CNT), 64'd0);
    repeat (2) tick();
    OPB_RST_N = 1'b1;
    sz = got_q.size();
    repeat (20) tick();
    chk("mid_rst_no_writes", 64'(got_q.size()), 64'(sz));
    chk("mid_rst_bytes", 64'(sz), 64'd5);
    clear_q();
    req(1'b1, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 8'h00);
    model_frame(1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 8'h00);
    wait_idle(100, 1'b0);
    cmp_frames("post_rst");
    $display("reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
